// File: rtl/misc_v_pkg.sv
// Shared MISC-V definitions: opcode field values and the sequencer state encoding.
// Both the multi-cycle sequencer and the per-instruction decode control unit use them.
package misc_v_pkg;

    localparam logic [2:0] OP_R    = 3'd0;
    localparam logic [2:0] OP_I    = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_BNE  = 3'd5;
    localparam logic [2:0] OP_JIN  = 3'd6;
    localparam logic [2:0] OP_JOUT = 3'd7;

    // Encodings 6 and 7 are named so the sequencer can recover from them explicitly.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ILL6   = 3'd6,
        ST_ILL7   = 3'd7
    } state_t;

endpackage

// File: rtl/retire_counter.sv
// Wrapping retired-instruction counter with synchronous reset and increment enable.
module retire_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (reset) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MISC-V datapath.
// Drives the per-cycle datapath enables and handshakes on the shared memory port.
module multicycle_sequencer
    import misc_v_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int STATE_W = 3
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               run,
    input  logic [2:0]         opcode,
    input  logic               mem_ready,
    input  logic               branch_taken,
    output logic               pc_write,
    output logic               ir_write,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_src,
    output logic               reg_write,
    output logic               alu_go,
    output logic               branch_eval,
    output logic               jump_out,
    output logic               retire,
    output logic               halted,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   instr_count
);

    state_t     state_q, state_d;
    logic [2:0] op_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    // Memory handshake: mem_req/mem_we/mem_src are held stable from the first
    // request cycle until a cycle with mem_ready=1, which completes the access.
    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_src     = 1'b0;
        reg_write   = 1'b0;
        alu_go      = 1'b0;
        branch_eval = 1'b0;
        jump_out    = 1'b0;
        retire      = 1'b0;
        halted      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                halted = 1'b1;
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                alu_go = 1'b1;
                case (op_q)
                    OP_R, OP_I:    state_d = ST_WB;
                    OP_LW, OP_SW:  state_d = ST_MEM;
                    OP_BEQ, OP_BNE: begin
                        branch_eval = 1'b1;
                        pc_write    = branch_taken;
                        retire      = 1'b1;
                    end
                    OP_JIN: begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                    default: begin
                        pc_write = 1'b1;
                        jump_out = 1'b1;
                        retire   = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_src = 1'b1;
                mem_we  = (op_q == OP_SW);
                if (mem_ready) begin
                    if (op_q == OP_SW) retire = 1'b1;
                    else               state_d = ST_WB;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // run is only honoured at instruction boundaries.
        if (retire) state_d = run ? ST_FETCH : ST_IDLE;
    end

    assign state = STATE_W'(state_q);

    retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
        .CLK   (CLK),
        .reset (reset),
        .inc   (retire),
        .count (instr_count)
    );

endmodule
